gen_counter: RTL and testbench

Parametrised up/down counter with modulus, prescaler, load, wrap/saturate mode and sticky overflow/underflow flags. It replaces fixed 4-bit up-counters in timer and event-count paths. One instance drives one count channel. All outputs are registered, and flags are raised only by actual count-step events, never by value inspection alone.

---
 rtl/gen_counter.sv | 99 +++++++++
 tb/tb_gen_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gen_counter.sv
// Up/down counter with modulus, prescaler, load, wrap/saturate and sticky flags.
// Optional compare output enabled by defining GEN_COUNTER_MATCH_EN.
module gen_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
`ifdef GEN_COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] match_val,
  output logic             match_out,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             tc_out
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_reg;
  logic [PW-1:0]    pre_reg;
  logic             ovf_reg, unf_reg, tc_reg;

  logic             step, at_max, at_zero, ovf_evt, unf_evt;
  logic [WIDTH-1:0] count_next, load_clamped;

  // Boundary tests use a zero-extended count so MAX_VAL = 2**WIDTH-1 cannot alias.
  always_comb begin
    step         = enable && !load && (pre_reg == PRE_LAST);
    at_max       = {1'b0, count_reg} >= MAX_EXT;
    at_zero      = (count_reg == '0);
    ovf_evt      = step && up_dn && at_max;
    unf_evt      = step && !up_dn && at_zero;
    load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;
    count_next   = count_reg;
    if (up_dn) begin
      if (at_max) count_next = sat_mode ? MAX_W : '0;
      else        count_next = count_reg + WIDTH'(1);
    end else begin
      if (at_zero) count_next = sat_mode ? '0 : MAX_W;
      else         count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      pre_reg   <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      tc_reg  <= ovf_evt | unf_evt;
      // A set event in the same cycle beats the clear.
      ovf_reg <= ovf_evt | (ovf_reg & ~clr_flags);
      unf_reg <= unf_evt | (unf_reg & ~clr_flags);
      if (load) begin
        count_reg <= load_clamped;
        pre_reg   <= '0;
      end else if (enable) begin
        if (step) begin
          count_reg <= count_next;
          pre_reg   <= '0;
        end else begin
          pre_reg <= pre_reg + PW'(1);
        end
      end
    end
  end

`ifdef GEN_COUNTER_MATCH_EN
  logic match_reg;

  always_ff @(posedge clk) begin
    if (reset) match_reg <= 1'b0;
    else       match_reg <= (load && (load_clamped == match_val)) ||
                            (step && (count_next == match_val));
  end

  assign match_out = match_reg;
`endif

  assign count_out     = count_reg;
  assign overflow_out  = ovf_reg;
  assign underflow_out = unf_reg;
  assign tc_out        = tc_reg;

endmodule

// File: tb/tb_gen_counter.sv
// Directed bench for gen_counter: WIDTH=4, MAX_VAL=9 with PRESCALE=1 (dut_a) and PRESCALE=3 (dut_b).
module tb_gen_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_en, a_up, a_sat, a_load, a_clr;
  logic [3:0] a_lv, a_mv, a_cnt;
  logic       a_ovf, a_unf, a_tc;
  logic       b_reset, b_en, b_up, b_sat, b_load, b_clr;
  logic [3:0] b_lv, b_mv, b_cnt;
  logic       b_ovf, b_unf, b_tc;
`ifdef GEN_COUNTER_MATCH_EN
  logic       a_match, b_match;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gen_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(a_reset), .enable(a_en), .up_dn(a_up), .sat_mode(a_sat),
    .load(a_load), .load_val(a_lv), .clr_flags(a_clr),
`ifdef GEN_COUNTER_MATCH_EN
    .match_val(a_mv), .match_out(a_match),
`endif
    .count_out(a_cnt), .overflow_out(a_ovf), .underflow_out(a_unf), .tc_out(a_tc)
  );

  gen_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_en), .up_dn(b_up), .sat_mode(b_sat),
    .load(b_load), .load_val(b_lv), .clr_flags(b_clr),
`ifdef GEN_COUNTER_MATCH_EN
    .match_val(b_mv), .match_out(b_match),
`endif
    .count_out(b_cnt), .overflow_out(b_ovf), .underflow_out(b_unf), .tc_out(b_tc)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int cnt, input int ovf, input int unf, input int tc);
    check_val({tag, ".cnt"}, 32'(a_cnt), 32'(cnt));
    check_val({tag, ".ovf"}, 32'(a_ovf), 32'(ovf));
    check_val({tag, ".unf"}, 32'(a_unf), 32'(unf));
    check_val({tag, ".tc"},  32'(a_tc),  32'(tc));
    $display("A %-10s cnt=%0d ovf=%0b unf=%0b tc=%0b", tag, a_cnt, a_ovf, a_unf, a_tc);
  endtask

  task automatic check_b(input string tag, input int cnt, input int ovf, input int tc);
    check_val({tag, ".cnt"}, 32'(b_cnt), 32'(cnt));
    check_val({tag, ".ovf"}, 32'(b_ovf), 32'(ovf));
    check_val({tag, ".tc"},  32'(b_tc),  32'(tc));
    $display("B %-10s cnt=%0d ovf=%0b tc=%0b", tag, b_cnt, b_ovf, b_tc);
  endtask

  int exp_b [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    {a_en, a_up, a_sat, a_load, a_clr} = '0; a_lv = '0; a_mv = 4'd5; a_reset = 1'b1;
    {b_en, b_up, b_sat, b_load, b_clr} = '0; b_lv = '0; b_mv = 4'd0; b_reset = 1'b1;
    tick();
    check_a("reset", 0, 0, 0, 0);
    check_b("reset", 0, 0, 0);

    // Wrap count 0..9,0 with a single tc pulse on the return to 0.
    a_reset = 1'b0; a_en = 1'b1; a_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_a($sformatf("wrap%0d", k), k % 10, (k == 10) ? 1 : 0, 0, (k == 10) ? 1 : 0);
`ifdef GEN_COUNTER_MATCH_EN
      check_val($sformatf("match%0d", k), 32'(a_match), (k == 5) ? 32'd1 : 32'd0);
`endif
    end

    // Load beats the step; flags untouched.
    a_load = 1'b1; a_lv = 4'd0;
    tick();
    check_a("load0", 0, 1, 0, 0);
    a_load = 1'b0;

    // Saturating down at 0: hold, underflow, tc every cycle.
    a_sat = 1'b1; a_up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a($sformatf("satdn%0d", k), 0, 1, 1, 1);
    end
    a_en = 1'b0; a_clr = 1'b1;
    tick();
    check_a("clr", 0, 0, 0, 0);
    a_clr = 1'b0;

    // Clamp on load; step in the same cycle is ignored.
    a_en = 1'b1; a_up = 1'b1; a_sat = 1'b0; a_load = 1'b1; a_lv = 4'd15;
    tick();
    check_a("clamp", 9, 0, 0, 0);
    a_lv = 4'd0;
    tick();
    a_load = 1'b0; a_up = 1'b0;
    tick();
    check_a("wrapdn", 9, 0, 1, 1);

    // Overflow event together with clear: overflow survives, underflow clears.
    a_up = 1'b1; a_clr = 1'b1;
    tick();
    check_a("ovfclr", 0, 1, 0, 1);
    a_clr = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_a("at7", 7, 1, 0, 0);
    a_reset = 1'b1;
    tick();
    check_a("midrst", 0, 0, 0, 0);
`ifdef GEN_COUNTER_MATCH_EN
    check_val("match_rst", 32'(a_match), 32'd0);
    a_reset = 1'b0; a_en = 1'b0; a_load = 1'b1; a_lv = 4'd5;
    tick();
    check_val("match_load", 32'(a_match), 32'd1);
    a_load = 1'b0;
    tick();
    check_val("match_off", 32'(a_match), 32'd0);
`endif

    // Prescaler of 3: steps on edges 3, 6, 9.
    b_reset = 1'b0; b_en = 1'b1; b_up = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_b($sformatf("pre%0d", k + 1), exp_b[k], 0, 0);
    end
    tick();
    check_b("pre10", 3, 0, 0);
    // Load mid-prescale clamps and restarts the prescaler.
    b_load = 1'b1; b_lv = 4'd15;
    tick();
    check_b("bload", 9, 0, 0);
    b_load = 1'b0;
    tick();
    check_b("bl1", 9, 0, 0);
    tick();
    check_b("bl2", 9, 0, 0);
    tick();
    check_b("bwrap", 0, 1, 1);
    tick();
    check_b("b15", 0, 1, 0);
    tick();
    tick();
    check_b("b17", 1, 1, 0);
    // Two enable-low cycles delay the next step by two edges.
    b_en = 1'b0;
    tick();
    tick();
    check_b("bhold", 1, 1, 0);
    b_en = 1'b1;
    tick();
    tick();
    check_b("b21", 1, 1, 0);
    tick();
    check_b("b22", 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
